// File: rtl/conv_bias_requant.sv
`default_nettype none
// ============================================================================
// Module   : conv_bias_requant
// Purpose  : Per-channel bias add, round, shift and saturate for conv1 results.
//            The CONV_BIAS_RELU_EN macro fuses a ReLU into the clamp.
// Revision : 1.0  initial release
// ============================================================================
module conv_bias_requant #(
    parameter int NUM_CH = 64,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8,
    parameter int CH_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0][31:0]  bias_mem,
    input  logic signed [31:0]       in_data,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              sat_count
);

    localparam int                RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [33:0] c_RND  = (SHIFT > 0) ? (34'sd1 <<< RND_POS) : 34'sd0;
    localparam logic signed [33:0] c_HI   = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
    localparam logic signed [33:0] c_MIN  = -(34'sd1 <<< (OUT_W - 1));
`ifdef CONV_BIAS_RELU_EN
    localparam logic signed [33:0] c_LO   = 34'sd0;
`else
    localparam logic signed [33:0] c_LO   = c_MIN;
`endif
    localparam logic [CH_W-1:0]    c_LAST = CH_W'(NUM_CH - 1);

    logic                     s1_valid_q, s1_valid_d;
    logic signed [32:0]       s1_sum_q, s1_sum_d;
    logic [CH_W-1:0]          s1_ch_q, s1_ch_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic [15:0]              sat_q, sat_d;
    logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;

    logic                     w_adv1, w_adv2, w_accept, w_over, w_under;
    logic [CH_W-1:0]          w_ch;
    logic signed [33:0]       w_rnd, w_q;

    always_comb begin
        w_adv2   = !out_valid_q || out_ready;
        w_adv1   = !s1_valid_q || w_adv2;
        w_accept = in_valid && w_adv1;
        w_ch     = in_sof ? '0 : ch_cnt_q;
        // 34 bits keep the rounding increment from overflowing a 33-bit sum
        w_rnd    = $signed({s1_sum_q[32], s1_sum_q}) + c_RND;
        w_q      = w_rnd >>> SHIFT;
        w_over   = w_q > c_HI;
        w_under  = w_q < c_MIN;

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_ch_d     = s1_ch_q;
        ch_cnt_d    = ch_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        sat_d       = sat_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = $signed({in_data[31], in_data})
                       + $signed({bias_mem[w_ch][31], bias_mem[w_ch]});
            s1_ch_d    = w_ch;
            ch_cnt_d   = (w_ch == c_LAST) ? '0 : w_ch + CH_W'(1);
        end else if (w_adv2) begin
            s1_valid_d = 1'b0;
        end

        if (w_adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (w_over)
                    out_data_d = c_HI[OUT_W-1:0];
                else if (w_q < c_LO)
                    out_data_d = c_LO[OUT_W-1:0];
                else
                    out_data_d = w_q[OUT_W-1:0];
                out_ch_d = s1_ch_q;
                if ((w_over || w_under) && (sat_q != 16'hFFFF))
                    sat_d = sat_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            ch_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sat_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_ch_q     <= s1_ch_d;
            ch_cnt_q    <= ch_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = w_adv1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign sat_count = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_bias_requant.sv
`default_nettype none
// Testbench for conv_bias_requant: directed steps plus random traffic, checked
// against an arithmetic reference model and an in-flight expectation queue.
module tb_conv_bias_requant;
    localparam int NUM_CH = 64, OUT_W = 16, SHIFT = 8, CH_W = 6;
    localparam longint HI = 32767, MIN = -32768;
`ifdef CONV_BIAS_RELU_EN
    localparam longint LO = 0;
    localparam bit RELU = 1'b1;
`else
    localparam longint LO = -32768;
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NUM_CH-1:0][31:0] bias_mem;
    logic signed [31:0] in_data = '0;
    logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic [CH_W-1:0] out_ch;
    logic [15:0] sat_count;

    conv_bias_requant #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .SHIFT(SHIFT), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .bias_mem(bias_mem), .in_data(in_data),
        .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .sat_count(sat_count));

    always #5 clk = ~clk;

    typedef struct { longint d; longint ch; int t; bit sat; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, mch = 0, exp_sat = 0, npop = 0;
    bit acc = 1'b0, hold = 1'b0;
    longint hold_d, hold_ch, last_d = 0, last_ch = 0, prev_ch = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact bias sum, round half up, floor divide, clamp
    function automatic exp_t model(input int din, input int ch);
        longint s, r, qq, div;
        exp_t e;
        div = longint'(1) << SHIFT;
        s   = longint'(din) + longint'($signed(bias_mem[ch]));
        r   = s + div / 2;
        qq  = r / div;
        if (r < 0 && qq * div != r) qq = qq - 1;
        e.sat = 1'b0;
        if (qq > HI)       begin e.d = HI; e.sat = 1'b1; end
        else if (qq < MIN) begin e.d = LO; e.sat = 1'b1; end
        else if (qq < LO)  e.d = 0;
        else               e.d = qq;
        e.ch = ch;
        e.t  = 0;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        int ch;
        #1;
        chk("in_ready", in_ready, (q.size() == 2 && !out_ready) ? 1'b0 : 1'b1);
        chk("out_valid", out_valid, (q.size() > 0 && cyc - q[0].t >= 2) ? 1'b1 : 1'b0);
        if (hold && out_valid) begin
            chk("hold_data", out_data, hold_d);
            chk("hold_ch", out_ch, hold_ch);
        end
        hold    = out_valid && !out_ready;
        hold_d  = out_data;
        hold_ch = out_ch;
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_ch", out_ch, e.ch);
            prev_ch = last_ch;
            last_d  = out_data;
            last_ch = out_ch;
            npop++;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            ch  = in_sof ? 0 : mch;
            e   = model(int'(in_data), ch);
            e.t = cyc;
            if (e.sat && exp_sat < 65535) exp_sat++;
            q.push_back(e);
            mch = (ch == NUM_CH - 1) ? 0 : ch + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input bit sof, input int d);
        in_valid = 1'b1; in_sof = sof; in_data = d;
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin tick(); n++; end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sof = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        q.delete(); mch = 0; hold = 1'b0; exp_sat = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int sent, k, n0;
        for (int i = 0; i < NUM_CH; i++)
            bias_mem[i] = 32'($urandom_range(0, 2**21)) - 32'd1048576;
        bias_mem[0] = 32'd3680;
        bias_mem[1] = 32'd453;
        bias_mem[7] = -32'sd87;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_sat", sat_count, 0);

        // basic latency: bias 3680, data 0 -> 14 two cycles later
        send(1'b1, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 14);
        chk("lat_ch", out_ch, 0);
        drain();

        // negative bias on channel 7
        for (int i = 1; i < 7; i++) send(1'b0, 0);
        send(1'b0, -1000);
        drain();
        chk("neg_ch", last_ch, 7);
        chk("neg_data", last_d, RELU ? 0 : -4);
        chk("neg_sat", sat_count, 0);

        // positive then negative saturation
        send(1'b1, 32'h7FFFFFFF);
        drain();
        chk("satp_data", last_d, 32767);
        chk("satp_cnt", sat_count, 1);
        send(1'b0, 32'h80000000);
        drain();
        chk("satn_data", last_d, RELU ? 0 : -32768);
        chk("satn_cnt", sat_count, 2);

        // 65 back-to-back beats: channel wraps to 0
        in_valid = 1'b1;
        for (int i = 0; i < 65; i++) begin
            in_sof = (i == 0); in_data = $urandom; tick();
        end
        in_valid = 1'b0; in_sof = 1'b0;
        drain();
        chk("wrap_prev", prev_ch, 63);
        chk("wrap_last", last_ch, 0);

        // sof mid-pixel restarts numbering
        for (int i = 0; i < 10; i++) send(i == 0, int'($urandom_range(0, 2**24)) - 8388608);
        send(1'b1, 5000);
        send(1'b0, -5000);
        drain();
        chk("sof_prev", prev_ch, 0);
        chk("sof_last", last_ch, 1);

        // backpressure with out_ready 1,0,0,1
        n0 = npop; sent = 0; k = 0;
        in_valid = 1'b1; in_data = int'($urandom_range(0, 2**24)) - 8388608;
        while (sent < 8 && k < 100) begin
            out_ready = pat[k % 4];
            tick();
            if (acc) begin sent++; in_data = int'($urandom_range(0, 2**24)) - 8388608; end
            k++;
        end
        in_valid = 1'b0;
        while (q.size() > 0 && k < 200) begin out_ready = pat[k % 4]; tick(); k++; end
        out_ready = 1'b1;
        drain();
        chk("bp_count", npop - n0, 8);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_sof    = ($urandom % 16) == 0;
            in_data   = ($urandom % 2) ? $urandom : int'($urandom_range(0, 2**24)) - 8388608;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        drain();
        chk("rand_sat", sat_count, exp_sat);

        // reset with beats in flight
        in_valid = 1'b1; in_data = 100; tick(); in_data = 200; tick();
        do_reset();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sat", sat_count, 0);
        tick();
        tick();
        send(1'b0, 1234);
        drain();
        chk("mrst_ch", last_ch, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
